// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in; results on a valid/ready port.
// Define PULSE_PERIOD_METER_SYNC_EN to add a two-flop input synchronizer for asynchronous pulse_in.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for the first edge of a fresh interval
//   MEASURE | counting cycles since the last edge; next edge publishes
module pulse_period_meter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         valid,
  input  logic         ready,
  output logic         overflow,
  output logic         miss
);

  localparam logic [0:0]   IDLE     = 1'b0;
  localparam logic [0:0]   MEASURE  = 1'b1;
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};

  logic         pulse_s;
  logic         prev;
  logic         pulse_edge;
  logic [0:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         publish;
  logic         ovf_set;
  logic         accept;
  logic         slot_free;

`ifdef PULSE_PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], pulse_in};
  end

  assign pulse_s = sync_q[1];
`else
  assign pulse_s = pulse_in;
`endif

  // prev tracks the input even while disabled so edges during ena=0 are consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= pulse_s;
  end

  assign pulse_edge = pulse_s & ~prev;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    publish = 1'b0;
    ovf_set = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (pulse_edge) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (pulse_edge) begin
            publish = 1'b1;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            // Saturate into overflow rather than wrapping; partial count is dropped.
            ovf_set = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept    = valid & ready;
  assign slot_free = ~valid | accept;

  // A result being accepted this cycle frees the slot for a simultaneous publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= '0;
      valid  <= 1'b0;
      miss   <= 1'b0;
    end else begin
      miss <= publish & ~slot_free;
      if (publish && slot_free) begin
        period <= cnt_q;
        valid  <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (accept)  overflow <= 1'b0;
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (N=8, synchronizer not compiled in).
module tb_pulse_period_meter;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       pulse_in;
  logic       ready;
  logic [7:0] period;
  logic       valid;
  logic       overflow;
  logic       miss;

  int n_vec;
  int n_err;

  pulse_period_meter #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .pulse_in (pulse_in),
    .period   (period),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow),
    .miss     (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic p, input logic e, input logic r);
    pulse_in = p;
    ena      = e;
    ready    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    pulse_in = 1'b0;
    ena      = 1'b0;
    ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Pulse train of period t with a high level of hi cycles, ready held high.
  task automatic train(input int t, input int hi, input int reps, input int exp_p);
    for (int r = 0; r < reps; r++) begin
      for (int j = 0; j < t; j++) begin
        cyc(j < hi, 1'b1, 1'b1);
        check("train_valid", valid, (r > 0 && j == 0));
        if (r > 0 && j == 0) check("train_period", period, exp_p);
        check("train_miss", miss, 0);
      end
    end
    check("train_overflow", overflow, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_period", period, 0);
    check("rst_overflow", overflow, 0);
    check("rst_miss", miss, 0);
    rst = 1'b1;

    train(5, 1, 5, 5);

    do_reset();
    train(7, 1, 4, 7);

    do_reset();
    train(2, 1, 5, 2);

    do_reset();
    train(9, 4, 4, 9);

    // Three disabled cycles stretch the wall-time interval to 12 but still count 9.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1);
    check("ena_first", valid, 0);
    for (int c = 1; c <= 3; c++) cyc(1'b1, 1'b1, 1'b1);
    for (int c = 4; c <= 6; c++) cyc(1'b0, 1'b0, 1'b1);
    for (int c = 7; c <= 11; c++) begin
      cyc(1'b0, 1'b1, 1'b1);
      check("ena_valid", valid, 0);
    end
    cyc(1'b1, 1'b1, 1'b1);
    check("ena_valid", valid, 1);
    check("ena_period", period, 9);

    // Backpressure: ready low for cycles 4..15, edges every 4 cycles.
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      cyc((c % 4) == 0, 1'b1, !(c >= 4 && c <= 15));
      check("bp_valid", valid, ((c >= 4 && c <= 16) || c == 20));
      if ((c >= 4 && c <= 16) || c == 20) check("bp_period", period, 4);
      check("bp_miss", miss, (c == 8 || c == 12));
    end

    // Overflow: single edge at cycle 0, flag visible after the clock of cycle 255.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      cyc(c == 0, 1'b1, 1'b1);
      if (c == 254 || c == 255 || c == 299) begin
        check("ovf_flag", overflow, (c >= 255));
        check("ovf_valid", valid, 0);
      end
    end
    for (int c = 0; c <= 11; c++) begin
      cyc(c == 0 || c == 10, 1'b1, 1'b1);
      if (c == 0) begin
        check("ovf_first_edge", valid, 0);
        check("ovf_held", overflow, 1);
      end
      if (c == 10) begin
        check("ovf_valid2", valid, 1);
        check("ovf_period", period, 10);
        check("ovf_held2", overflow, 1);
      end
      if (c == 11) begin
        check("ovf_accept_valid", valid, 0);
        check("ovf_cleared", overflow, 0);
      end
    end

    // Reset mid-measurement with a held result and a pending interval.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      cyc((c % 5) == 0, 1'b1, 1'b0);
      if (c == 5) check("mid_pre_period", period, 5);
      if (c == 10) check("mid_pre_miss", miss, 1);
    end
    rst = 1'b0;
    #1;
    check("mid_valid", valid, 0);
    check("mid_period", period, 0);
    check("mid_overflow", overflow, 0);
    check("mid_miss", miss, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_valid_held", valid, 0);
    rst = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      cyc(c == 0 || c == 6, 1'b1, 1'b1);
      check("post_valid", valid, (c == 6));
      if (c == 6) check("post_period", period, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
